// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// latency counter width and the legal LATENCY range.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CNT_W   = 4;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 32-bit storage: one synchronous write port, one combinational
// read port, every word cleared by the asynchronous reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 32,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the CPU MEM stage: accepts one access
// in IDLE, waits LATENCY cycles, completes it in DONE with a one-cycle ack.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int                AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0]       ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("data_mem_responder: LATENCY out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             we_q;
    logic [31:0]      addr_q, wdata_q;

    logic             accept, enter_done, arr_we;
    logic             acc_we, acc_legal;
    logic [31:0]      acc_addr, acc_wdata, arr_rdata;

    assign accept = req_i && (state_q == ST_IDLE);

    // With LATENCY=1 the access executes on the acceptance edge, before the
    // request has been latched, so the live inputs are used while in IDLE.
    assign acc_we     = (state_q == ST_IDLE) ? we_i    : we_q;
    assign acc_addr   = (state_q == ST_IDLE) ? addr_i  : addr_q;
    assign acc_wdata  = (state_q == ST_IDLE) ? wdata_i : wdata_q;
    assign acc_legal  = (acc_addr[1:0] == 2'b00) && (acc_addr < ADDR_LIMIT);
    assign enter_done = (state_d == ST_DONE);
    assign arr_we     = enter_done && acc_we && acc_legal;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (arr_we),
        .waddr_i (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .raddr_i (acc_addr[AW+1:2]),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (LATENCY == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d   = 1'b0;
        rdata_d = rdata_q;
        if (enter_done) begin
            err_d = !acc_legal;
            if (!acc_we) begin
                rdata_d = acc_legal ? arr_rdata : '0;
            end
        end
    end

    always_comb begin
        ready_o = (state_q == ST_IDLE);
        ack_o   = (state_q == ST_DONE);
        stall_o = req_i && (state_q != ST_DONE);
        err_o   = err_q;
        rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: two responders (LATENCY 3 and 1) checked
// against a word-array model with latency and legality rules applied directly.
module tb_data_mem_responder;

    localparam int DEPTH = 32;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        ack   [2];
    logic        err   [2];
    logic        stall [2];
    logic [31:0] rdata [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] rd_m  [2];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .stall_o(stall[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .stall_o(stall[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int s);
        return (s == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            rd_m[s] = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[s][i] = '0;
        end
    endtask

    // Applies the completion rules of one access to the model of instance s.
    task automatic model_complete(input int s, input bit w, input logic [31:0] a,
                                  input logic [31:0] d, output bit exp_err);
        bit legal;
        legal   = (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
        exp_err = !legal;
        if (w) begin
            if (legal) mem_m[s][a >> 2] = d;
        end else begin
            rd_m[s] = legal ? mem_m[s][a >> 2] : 32'h0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        model_reset();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk_eq("rst_ready", ready[s], 1'b1);
            chk_eq("rst_ack", ack[s], 1'b0);
            chk_eq("rst_err", err[s], 1'b0);
            chk_eq("rst_rdata", rdata[s], 32'h0);
            chk_eq("rst_stall", stall[s], 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One complete access on instance s; call just after a rising edge.
    task automatic access(input int s, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
        int n, acc_cyc;
        bit exp_err;
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        n = 0;
        @(negedge clk);
        while (!ready[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready[s]) begin
            chk_eq("ready_timeout", ready[s], 1'b1);
            req[s] = 1'b0;
            return;
        end
        chk_eq("acc_stall", stall[s], 1'b1);
        acc_cyc = cyc;
        model_complete(s, w, a, d, exp_err);
        @(posedge clk); #1;
        req[s] = 1'b0;
        if (scramble) begin
            we[s] = ~w; addr[s] = $urandom; wdata[s] = $urandom;
        end
        n = 0;
        @(negedge clk);
        while (!ack[s] && n < 40) begin
            chk_eq("busy_ready", ready[s], 1'b0);
            @(negedge clk);
            n++;
        end
        chk_eq("ack_latency", 32'(cyc - acc_cyc), 32'(lat_of(s)));
        chk_eq("ack_err", err[s], exp_err);
        chk_eq("ack_rdata", rdata[s], rd_m[s]);
        @(negedge clk);
        chk_eq("ack_pulse", ack[s], 1'b0);
        chk_eq("idle_ready", ready[s], 1'b1);
        @(posedge clk); #1;
    endtask

    // req held high over four back-to-back accesses on the LATENCY=3 instance.
    task automatic queued();
        logic [31:0] qa [4];
        logic [31:0] qd [4];
        bit          qw [4];
        int acc_prev, exp_ack, k, done;
        bit pend_err;
        qa = '{32'h20, 32'h20, 32'h24, 32'h24};
        qd = '{32'hCAFE0001, 32'h0, 32'h5555AAAA, 32'h0};
        qw = '{1'b1, 1'b0, 1'b1, 1'b0};
        acc_prev = -1; exp_ack = -1; k = 0; done = 0; pend_err = 1'b0;
        req[0] = 1'b1; we[0] = qw[0]; addr[0] = qa[0]; wdata[0] = qd[0];
        for (int t = 0; t < 60 && done < 4; t++) begin
            @(negedge clk);
            chk_eq("q_ack", ack[0], cyc == exp_ack);
            chk_eq("q_stall", stall[0], req[0] && (cyc != exp_ack));
            if (cyc == exp_ack) begin
                chk_eq("q_err", err[0], pend_err);
                chk_eq("q_rdata", rdata[0], rd_m[0]);
                done++;
            end
            if (ready[0] && req[0]) begin
                if (acc_prev >= 0) chk_eq("q_spacing", 32'(cyc - acc_prev), 32'(LAT_A + 1));
                acc_prev = cyc;
                exp_ack  = cyc + LAT_A;
                model_complete(0, qw[k], qa[k], qd[k], pend_err);
                k++;
                @(posedge clk); #1;
                if (k < 4) begin
                    we[0] = qw[k]; addr[0] = qa[k]; wdata[0] = qd[k];
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        if (done < 4) chk_eq("q_timeout", done, 4);
        req[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        do_reset();

        access(1, 1'b0, 32'h0, 32'h0, 1'b0);
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0);
        access(0, 1'b0, 32'h12, 32'h0, 1'b0);
        access(0, 1'b1, 32'h80, 32'h77777777, 1'b0);
        access(0, 1'b0, 32'h0, 32'h0, 1'b0);
        access(0, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b1);
        access(0, 1'b0, 32'h8, 32'h0, 1'b1);
        access(1, 1'b1, 32'h7C, 32'h13579BDF, 1'b1);
        access(1, 1'b0, 32'h7C, 32'h0, 1'b0);
        queued();

        // Reset while a write is in BUSY: the write is dropped and no ack appears.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4; wdata[0] = 32'h1234;
        @(negedge clk);
        chk_eq("abort_accept", ready[0], 1'b1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk_eq("abort_busy", ready[0], 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk_eq("abort_rst_ready", ready[0], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("abort_no_ack", ack[0], 1'b0);
        end
        @(posedge clk); #1;
        access(0, 1'b0, 32'h4, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int s, r;
            logic [31:0] a;
            s = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0)      a = {25'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))} & 32'h7F | 32'h1;
            else if (r == 1) a = 32'(4 * DEPTH) + ($urandom & 32'hFFFF_FFFC) % 32'h1000_0000;
            else if (r < 6)  a = {28'($urandom_range(0, 7)), 2'b00};
            else             a = {25'($urandom_range(0, DEPTH - 1)), 2'b00};
            access(s, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 32, meaning the number of 32-bit storage words (power of two, 4..256).
REQ-002 The block SHALL have parameter LATENCY, default 3, meaning the cycles from request acceptance to ack (legal range 1..15).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_i, input, 1 bit: the MEM stage requests an access.
REQ-006 The block SHALL have port we_i, input, 1 bit: 1 = write, 0 = read; sampled with req_i.
REQ-007 The block SHALL have port addr_i, input, 32 bits: byte address; sampled with req_i.
REQ-008 The block SHALL have port wdata_i, input, 32 bits: write data; sampled with req_i.
REQ-009 The block SHALL have port ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-010 The block SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rdata_o, output, 32 bits: read data, valid while ack_o=1 for reads.
REQ-012 The block SHALL have port err_o, output, 1 bit: the completing access was illegal; valid only with ack_o.
REQ-013 The block SHALL have port stall_o, output, 1 bit: pipeline hold request to the CPU hazard logic.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015 ready_o SHALL be 1 only in IDLE; a request is accepted on the edge where req_i=1 and ready_o=1, latching we_i, addr_i and wdata_i.
REQ-016 On acceptance the FSM SHALL go to DONE if LATENCY=1; otherwise it SHALL go to BUSY with a 4-bit counter loaded to LATENCY-2.
REQ-017 In BUSY, if the counter is 0 the FSM SHALL go to DONE; otherwise the counter SHALL decrement.
REQ-018 On the edge entering DONE, the latched access SHALL execute: a write updates the word, and a read loads rdata_o from the array.
REQ-019 In DONE, ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL return unconditionally to IDLE; ack_o therefore rises exactly LATENCY cycles after the acceptance cycle.
REQ-020 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-021 The access SHALL be illegal if addr[1:0]!=0 or addr >= 4*DEPTH_WORDS; an illegal access does not write, sets rdata_o=0 and sets err_o=1 in the DONE cycle.
REQ-022 rdata_o SHALL hold its last value except on a read completion; a write completion leaves rdata_o unchanged.
REQ-023 stall_o SHALL equal req_i AND (state != DONE), so a requesting stage holds until its ack cycle.
REQ-024 Changes on req_i, we_i, addr_i or wdata_i after acceptance SHALL NOT affect the in-flight access.
REQ-025 A request asserted during BUSY or DONE SHALL NOT be accepted; it is accepted in the next IDLE cycle, giving a maximum throughput of one access per LATENCY+1 cycles.
REQ-026 In IDLE with req_i=0, the FSM SHALL remain in IDLE with no side effects.

Reset
REQ-027 While rst_i=0 the block SHALL force: state=IDLE, counter=0, ack_o=0, err_o=0, rdata_o=0, and all array words to 0; ready_o is then 1.
REQ-028 A reset asserted mid-transaction SHALL abort the transaction with no write performed and no ack issued.

Structure
REQ-029 The shared package dmem_pkg SHALL hold the FSM state enum, the counter width constant (4) and the LATENCY legal-range constants.
REQ-030 Storage SHALL be a single sub-module, dmem_array, with one synchronous write port, one read port and array-wide reset; the FSM, counter and address check SHALL reside in data_mem_responder.

Verification
REQ-031 Scenario: reset, write 0xDEADBEEF to 0x10, then read 0x10 -> each ack 3 cycles after acceptance; read gives rdata_o=0xDEADBEEF with err_o=0.
REQ-032 Scenario: read 0x12, then write to 0x80 (DEPTH=32) -> both ack with err_o=1, the read gives rdata_o=0, and a later read of word 0 returns 0.
REQ-033 Scenario: req_i held high with 4 queued accesses -> acceptances spaced 4 cycles apart, stall_o low only in ack cycles.
REQ-034 Scenario: LATENCY=1, read 0x0 after reset -> ack_o in the cycle after acceptance with rdata_o=0.
REQ-035 Scenario: assert rst_i=0 during BUSY of a write of 0x1234 to 0x4 -> no ack; a subsequent read of 0x4 returns 0.
REQ-036 Scenario: change addr_i and wdata_i the cycle after accepting a write of 0xA5A5A5A5 to 0x8 -> a read of 0x8 returns 0xA5A5A5A5.
